// File: rtl/lane_cmp_arbiter_if.sv
// ---------------------------------------------------------------------------
// lane_cmp_arbiter_if
// Bundles the lane request bus and the tagged response bus of
// lane_cmp_arbiter.
//
//   req_valid  [NUM_REQ]        per-lane request (lane -> arbiter)
//   req_a      [NUM_REQ*WIDTH]  lane i operand A in [i*WIDTH +: WIDTH]
//   req_b      [NUM_REQ*WIDTH]  lane i operand B, same packing
//   req_ready  [NUM_REQ]        one-hot grant (arbiter -> lane)
//   rsp_valid                   one-cycle response strobe
//   rsp_id     [ID_W]           lane index of the response
//   rsp_match                   1 when A == B over all WIDTH bits
//   toggle_err                  toggle violation, qualified by rsp_valid
//   busy                        arbiter is in CMP or RSP
//
// Handshake: a request transfers in the cycle where req_valid[i] and
// req_ready[i] are both high. A lane keeps req_valid and its operands
// stable until that cycle. The response has no backpressure; the consumer
// takes it in the single rsp_valid cycle.
//
// master modport: the lane side. slave modport: the arbiter.
// ---------------------------------------------------------------------------
interface lane_cmp_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int WIDTH   = 16
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     rsp_valid;
    logic [ID_W-1:0]          rsp_id;
    logic                     rsp_match;
    logic                     toggle_err;
    logic                     busy;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_id, rsp_match, toggle_err, busy
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_id, rsp_match, toggle_err, busy
    );
endinterface

// File: rtl/lane_cmp_arbiter.sv
// ---------------------------------------------------------------------------
// lane_cmp_arbiter
// Round-robin arbiter and sequencer sharing one WIDTH-bit equality
// comparator between NUM_REQ lanes. One lane is granted at a time. Its
// operands are registered and compared. A one-cycle tagged response is
// returned two cycles after the transfer.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   bus        lane_cmp_arbiter_if.slave (request and response buses)
//   dbg_state  current FSM state (0 IDLE, 1 CMP, 2 RSP)
//
// Optional feature macro: LANE_CMP_TOGGLE_CHECK_EN
//   When defined, a per-lane history flags a lane whose result equals its
//   previous result. When undefined, toggle_err is tied to 0 and there are
//   no history registers.
// ---------------------------------------------------------------------------
module lane_cmp_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int WIDTH   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    lane_cmp_arbiter_if.slave    bus,
    output logic [1:0]           dbg_state
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic               rsp_match_q, rsp_match_d;

`ifdef LANE_CMP_TOGGLE_CHECK_EN
    logic [NUM_REQ-1:0] prev_match_q, prev_match_d;
    logic [NUM_REQ-1:0] prev_seen_q, prev_seen_d;
    logic               toggle_err_q, toggle_err_d;
`endif

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    cand;
    logic               found;
    logic               transfer;
    logic               match;

    // Grant scan: first valid lane at or above ptr, wrapping modulo
    // NUM_REQ. Depends only on req_valid, ptr, state and reset; never on
    // the operands. Held at zero during reset and outside IDLE.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        cand     = '0;
        found    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
                found    = 1'b1;
                grant_id = cand;
            end
        end
        if (found && (state_q == IDLE) && !reset) begin
            grant = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
        end
    end

    assign transfer = |(grant & bus.req_valid);
    assign match    = (a_q == b_q);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_id_d    = rsp_id_q;
        rsp_match_d = rsp_match_q;
`ifdef LANE_CMP_TOGGLE_CHECK_EN
        prev_match_d = prev_match_q;
        prev_seen_d  = prev_seen_q;
        toggle_err_d = toggle_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    a_d     = bus.req_a[int'(grant_id)*WIDTH +: WIDTH];
                    b_d     = bus.req_b[int'(grant_id)*WIDTH +: WIDTH];
                    id_d    = grant_id;
                    state_d = CMP;
                end
            end
            CMP: begin
                // Response fields are loaded here so they appear exactly in
                // the RSP cycle and then hold until the next response.
                rsp_match_d = match;
                rsp_id_d    = id_q;
`ifdef LANE_CMP_TOGGLE_CHECK_EN
                toggle_err_d = prev_seen_q[id_q] & (match == prev_match_q[id_q]);
`endif
                state_d = RSP;
            end
            RSP: begin
                ptr_d = ID_W'((int'(id_q) + 1) % NUM_REQ);
`ifdef LANE_CMP_TOGGLE_CHECK_EN
                prev_match_d[id_q] = rsp_match_q;
                prev_seen_d[id_q]  = 1'b1;
                toggle_err_d       = 1'b0;
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_id_q    <= '0;
            rsp_match_q <= 1'b0;
`ifdef LANE_CMP_TOGGLE_CHECK_EN
            prev_match_q <= '0;
            prev_seen_q  <= '0;
            toggle_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_id_q    <= rsp_id_d;
            rsp_match_q <= rsp_match_d;
`ifdef LANE_CMP_TOGGLE_CHECK_EN
            prev_match_q <= prev_match_d;
            prev_seen_q  <= prev_seen_d;
            toggle_err_q <= toggle_err_d;
`endif
        end
    end

    // Strobes are gated by reset so a transaction caught by reset in CMP
    // or RSP never produces a response.
    assign bus.req_ready = grant;
    assign bus.rsp_valid = (state_q == RSP) & ~reset;
    assign bus.busy      = (state_q != IDLE) & ~reset;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_match = rsp_match_q;
`ifdef LANE_CMP_TOGGLE_CHECK_EN
    assign bus.toggle_err = toggle_err_q & bus.rsp_valid;
`else
    assign bus.toggle_err = 1'b0;
`endif
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lane_cmp_arbiter.sv
module tb_lane_cmp_arbiter;
  localparam int NUM_REQ = 3;
  localparam int WIDTH   = 16;
`ifdef LANE_CMP_TOGGLE_CHECK_EN
  localparam bit TOG_EN = 1'b1;
`else
  localparam bit TOG_EN = 1'b0;
`endif

  // clock / reset
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  always #5 clock = ~clock;

  lane_cmp_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  lane_cmp_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_lane(input int lane, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.req_a[lane*WIDTH +: WIDTH] = a;
    bus.req_b[lane*WIDTH +: WIDTH] = b;
  endtask

  // One full transaction starting in an IDLE cycle: transfer at T,
  // CMP at T+1, response at T+2, returns at T+3.
  task automatic txn(input logic [2:0] mask, input int lane, input logic hold,
                     input logic exp_match, input logic exp_tog, input string tag);
    bus.req_valid = mask;
    #1;
    chk({tag, " grant"}, 32'(bus.req_ready), 32'(1 << lane));
    chk({tag, " rsp_valid_T"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, " busy_T"}, 32'(bus.busy), 32'd0);
    tick();
    if (!hold) bus.req_valid[lane] = 1'b0;
    #1;
    chk({tag, " ready_T1"}, 32'(bus.req_ready), 32'd0);
    chk({tag, " busy_T1"}, 32'(bus.busy), 32'd1);
    chk({tag, " rsp_valid_T1"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, " state_T1"}, 32'(dbg_state), 32'd1);
    tick();
    chk({tag, " rsp_valid_T2"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, " rsp_id"}, 32'(bus.rsp_id), 32'(lane));
    chk({tag, " rsp_match"}, 32'(bus.rsp_match), 32'(exp_match));
    chk({tag, " toggle_err"}, 32'(bus.toggle_err), 32'(exp_tog));
    chk({tag, " busy_T2"}, 32'(bus.busy), 32'd1);
    chk({tag, " state_T2"}, 32'(dbg_state), 32'd2);
    tick();
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    reset         = 1'b1;

    // reset state, with all lanes requesting during reset
    tick();
    bus.req_valid = 3'b111;
    #1;
    chk("rst ready", 32'(bus.req_ready), 32'd0);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst rsp_match", 32'(bus.rsp_match), 32'd0);
    chk("rst toggle_err", 32'(bus.toggle_err), 32'd0);
    chk("rst state", 32'(dbg_state), 32'd0);
    tick();
    reset = 1'b0;
    bus.req_valid = '0;

    // round robin: lane0 match, lane1 mismatch, lane2 match, held valid
    set_lane(0, 16'hAAAA, 16'hAAAA);
    set_lane(1, 16'h0001, 16'h0002);
    set_lane(2, 16'h0000, 16'h0000);
    for (int g = 0; g < 9; g++) begin
      txn(3'b111, g % 3, 1'b1, (g % 3) != 1, TOG_EN && (g >= 3), "rr");
    end

    // pointer resume: lanes 0 and 2 valid
    txn(3'b101, 0, 1'b0, 1'b1, TOG_EN, "resume0");
    txn(3'b101, 2, 1'b0, 1'b1, TOG_EN, "resume2");
    txn(3'b101, 0, 1'b0, 1'b1, TOG_EN, "resume0b");

    // single request, lane 1 equal operands
    set_lane(1, 16'h1234, 16'h1234);
    txn(3'b010, 1, 1'b0, 1'b1, 1'b0, "single");

    // MSB-only difference on lane 0
    set_lane(0, 16'hFFFF, 16'h7FFF);
    txn(3'b001, 0, 1'b0, 1'b0, 1'b0, "msb");

    // reset in the CMP cycle (ptr is 1 here)
    set_lane(2, 16'h0003, 16'h0003);
    bus.req_valid = 3'b100;
    #1;
    chk("midrst grant", 32'(bus.req_ready), 32'b100);
    tick();
    bus.req_valid = '0;
    reset = 1'b1;
    #1;
    chk("midrst rsp_valid_rc", 32'(bus.rsp_valid), 32'd0);
    chk("midrst busy_rc", 32'(bus.busy), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("midrst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst busy", 32'(bus.busy), 32'd0);
    chk("midrst rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("midrst rsp_match", 32'(bus.rsp_match), 32'd0);
    chk("midrst toggle_err", 32'(bus.toggle_err), 32'd0);
    chk("midrst state", 32'(dbg_state), 32'd0);
    tick();
    chk("midrst rsp_valid2", 32'(bus.rsp_valid), 32'd0);
    txn(3'b111, 0, 1'b0, 1'b0, 1'b0, "post_rst");

    // toggle history on lane 2: match, mismatch, mismatch
    txn(3'b100, 2, 1'b0, 1'b1, 1'b0, "tog1");
    set_lane(2, 16'h0003, 16'h0004);
    txn(3'b100, 2, 1'b0, 1'b0, 1'b0, "tog2");
    set_lane(2, 16'h0005, 16'h0006);
    txn(3'b100, 2, 1'b0, 1'b0, TOG_EN, "tog3");

    // lane 1 requests only while the arbiter is busy, then withdraws
    bus.req_valid = 3'b001;
    #1;
    chk("drop grant0", 32'(bus.req_ready), 32'b001);
    tick();
    bus.req_valid = 3'b010;
    #1;
    chk("drop ready_cmp", 32'(bus.req_ready), 32'd0);
    tick();
    chk("drop rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("drop rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("drop rsp_match", 32'(bus.rsp_match), 32'd0);
    chk("drop toggle_err", 32'(bus.toggle_err), 32'(TOG_EN));
    bus.req_valid = 3'b000;
    tick();
    chk("drop ready_idle", 32'(bus.req_ready), 32'd0);
    chk("drop rsp_valid_idle", 32'(bus.rsp_valid), 32'd0);
    chk("drop toggle_err_idle", 32'(bus.toggle_err), 32'd0);
    chk("drop rsp_id_hold", 32'(bus.rsp_id), 32'd0);
    tick();
    chk("drop busy", 32'(bus.busy), 32'd0);
    chk("drop state", 32'(dbg_state), 32'd0);

    // single valid lane is granted back-to-back
    set_lane(1, 16'h0005, 16'h0005);
    txn(3'b010, 1, 1'b1, 1'b1, 1'b0, "b2b0");
    txn(3'b010, 1, 1'b1, 1'b1, TOG_EN, "b2b1");
    bus.req_valid = '0;
    tick();
    chk("end rsp_match_hold", 32'(bus.rsp_match), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
